// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream width converters.
//   AXIS_BYTE_W        : bits per byte lane slice
//   axis_lane_order_t  : which lane of a wide beat is emitted first
//   axis_idx_width()   : width of a lane index for a given lane count (min 1)
//   axis_lane_width()  : bit width of a narrow beat of a given byte count
package axis_pkg;

  localparam int unsigned AXIS_BYTE_W = 8;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } axis_lane_order_t;

  function automatic int unsigned axis_idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned axis_lane_width(input int unsigned bytes);
    return bytes * AXIS_BYTE_W;
  endfunction

endpackage

// File: rtl/axis_keep_last_idx.sv
// Priority encoder: index of the highest set bit of a lane keep vector.
// An all-zero keep reports index 0, so a last beat always yields one lane.
//   keep_i     : per-lane keep bits (RATIO wide)
//   last_idx_o : highest set lane index (clog2(RATIO) wide, min 1)
module axis_keep_last_idx
  import axis_pkg::*;
#(
  parameter int unsigned RATIO = 4
) (
  input  logic [RATIO-1:0]                  keep_i,
  output logic [axis_idx_width(RATIO)-1:0]  last_idx_o
);

  localparam int unsigned IDX_W = axis_idx_width(RATIO);

  always_comb begin
    last_idx_o = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (keep_i[i]) last_idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/axis_downsizer.sv
// AXI-Stream downsizer: splits each wide input beat into up to RATIO narrow
// output beats. A last beat emits lanes up to its highest kept lane and
// carries tlast on that lane; tuser is repeated on every narrow beat.
// The next wide beat is accepted in the same cycle the final lane hands off,
// so an unstalled consumer sees no bubbles.
//   clk, aresetn        : clock, asynchronous active-low reset
//   axis_i_*            : wide AXIS slave (tready depends combinationally
//                         on axis_o_tready)
//   axis_o_*            : narrow AXIS master
module axis_downsizer #(
  parameter int unsigned AXIS_O_BYTES   = 1,
  parameter int unsigned RATIO          = 4,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter bit          MSB_FIRST      = 1'b0
) (
  input  logic                            clk,
  input  logic                            aresetn,
  output logic                            axis_i_tready,
  input  logic                            axis_i_tvalid,
  input  logic                            axis_i_tlast,
  input  logic [RATIO*AXIS_O_BYTES*8-1:0] axis_i_tdata,
  input  logic [RATIO-1:0]                axis_i_tkeep,
  input  logic [AXIS_USER_BITS-1:0]       axis_i_tuser,
  input  logic                            axis_o_tready,
  output logic                            axis_o_tvalid,
  output logic                            axis_o_tlast,
  output logic [AXIS_O_BYTES*8-1:0]       axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]       axis_o_tuser
);

  import axis_pkg::*;

  localparam int unsigned IDX_W  = axis_idx_width(RATIO);
  localparam int unsigned LANE_W = axis_lane_width(AXIS_O_BYTES);
  localparam int unsigned IN_W   = RATIO * LANE_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);
  localparam axis_lane_order_t ORDER =
    MSB_FIRST ? axis_pkg::MSB_FIRST : axis_pkg::LSB_FIRST;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [IN_W-1:0]           data_q, data_d;
  logic [AXIS_USER_BITS-1:0] user_q, user_d;
  logic                      last_q, last_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          last_idx_q, last_idx_d;

  logic [IDX_W-1:0]          keep_idx;
  logic                      hold_valid;
  logic                      out_hs;
  logic                      final_lane;
  logic                      in_acc;
  logic [IDX_W-1:0]          lane_sel;

  axis_keep_last_idx #(
    .RATIO (RATIO)
  ) u_keep_last_idx (
    .keep_i     (axis_i_tkeep),
    .last_idx_o (keep_idx)
  );

  assign hold_valid = (state_q == ST_DRAIN);
  assign out_hs     = hold_valid && axis_o_tready;
  assign final_lane = (idx_q == last_idx_q);

  // Refill when empty, or when the final lane leaves this very cycle.
  assign axis_i_tready = aresetn && (!hold_valid || (out_hs && final_lane));
  assign in_acc        = axis_i_tvalid && axis_i_tready;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    user_d     = user_q;
    last_d     = last_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    if (in_acc) begin
      state_d    = ST_DRAIN;
      data_d     = axis_i_tdata;
      user_d     = axis_i_tuser;
      last_d     = axis_i_tlast;
      idx_d      = '0;
      last_idx_d = axis_i_tlast ? keep_idx : IDX_MAX;
    end else if (out_hs) begin
      if (final_lane) begin
        state_d = ST_EMPTY;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_EMPTY;
      data_q     <= '0;
      user_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      user_q     <= user_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  // Lane order only changes which physical slice an index maps to; the
  // partial-beat count always starts at the first emitted lane.
  assign lane_sel = (ORDER == axis_pkg::MSB_FIRST) ? (IDX_MAX - idx_q) : idx_q;

  always_comb begin
    axis_o_tdata = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (lane_sel == IDX_W'(i)) axis_o_tdata = data_q[i*LANE_W +: LANE_W];
    end
  end

  assign axis_o_tvalid = hold_valid;
  assign axis_o_tuser  = user_q;
  assign axis_o_tlast  = last_q && final_lane;

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- Width converter sitting directly downstream of the AXIS FIFO output stage.
- Splits each wide input beat into RATIO narrow output beats, for narrow consumers such as a byte-wide UART or SPI framer.
- Supports a partial final beat via a lane-granular keep, propagates tuser to every output beat, and moves tlast to the last emitted lane.
- Full throughput: when downstream never stalls, no bubbles appear between consecutive input beats.

Parameters:
- AXIS_O_BYTES, 1: output data width in bytes.
- RATIO, 4: output beats per input beat. Must be ≥2. Input width is RATIO*AXIS_O_BYTES bytes.
- AXIS_USER_BITS, 1: tuser width, passed through unchanged.
- MSB_FIRST, 0: 0 emits lane 0 (least significant slice) first; 1 emits lane RATIO-1 first.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  input end of packet
- axis_i_tdata  in  RATIO*AXIS_O_BYTES*8  input data
- axis_i_tkeep  in  RATIO  per-lane keep; only honoured when tlast is set
- axis_i_tuser  in  AXIS_USER_BITS  input sideband
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast  out  1  output end of packet
- axis_o_tdata  out  AXIS_O_BYTES*8  output data
- axis_o_tuser  out  AXIS_USER_BITS  output sideband

Behaviour:
- Clock and reset: one clock, clk. Reset is aresetn, asynchronous and active-low. While aresetn is low, all state clears immediately.
- Reset values: axis_o_tvalid=0, axis_o_tlast=0; lane index=0; hold_valid=0. axis_i_tready is forced 0 while aresetn=0.
- State: holding register (data, tuser, tlast), hold_valid, lane index idx of width clog2(RATIO), and last_idx.
- States:
  - EMPTY: hold_valid=0.
  - DRAIN: hold_valid=1, idx counting from 0 to last_idx.
- Input accept: occurs when axis_i_tvalid && axis_i_tready.
  - axis_i_tready = aresetn && (!hold_valid || (axis_o_tvalid && axis_o_tready && idx==last_idx)).
  - This is a combinational dependency on axis_o_tready; it is documented for integrators.
- On accept: load the holding register, set hold_valid=1, set idx=0.
  - last_idx = RATIO-1 when tlast=0.
  - When tlast=1, last_idx = index of the highest set keep bit.
  - An all-zero keep with tlast=1 is treated as keep=1: one lane is emitted, so tlast is never lost.
- Latency: a beat accepted at edge N presents lane 0 with axis_o_tvalid=1 in the cycle after edge N.
- Output:
  - axis_o_tvalid = hold_valid.
  - axis_o_tdata = slice selected by idx, or by RATIO-1-idx when MSB_FIRST=1.
  - axis_o_tuser = held tuser.
  - axis_o_tlast = held tlast && idx==last_idx.
- Output handshake: on an output handshake with idx<last_idx, idx increments.
- Final lane, no new input: on an output handshake with idx==last_idx and no simultaneous input accept, hold_valid goes to 0 and the block returns to EMPTY.
- Final lane with new input: last-lane handshake and input accept in the same cycle loads the new beat with idx=0. axis_o_tvalid stays 1, so there is no bubble.
- Stall: with axis_o_tready=0, all output signals hold stable. AXIS rule: valid is never withdrawn before it is accepted.
- Keep on non-last beats is ignored; all RATIO lanes are emitted. The bench asserts keep is all-ones on non-last beats as a protocol check.
- Reset mid-packet: the held beat is discarded. After reset release the block starts in EMPTY and outputs no partial remainder.

Decomposition:
- Package axis_pkg holds:
  - the clog2-based index width function,
  - a localparam helper for the lane width,
  - the axis_lane_order_t enum (LSB_FIRST, MSB_FIRST), used to give meaning to the MSB_FIRST parameter.
- Sub-module axis_keep_last_idx: combinational priority encoder from RATIO keep bits to the highest-set index, with the zero→0 rule. It is reused by a future axis_upsizer.

Test Plan:
- Basic order: RATIO=4, AXIS_O_BYTES=1, MSB_FIRST=0, input 0xDDCCBBAA, tlast=1, keep=4'b1111, tready=1 → outputs 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles; tlast only on 0xDD.
- Throughput: 3 back-to-back input beats with tlast=0,0,1 and tready=1 → 12 output beats with no bubbles; axis_i_tready pulses high on every 4th cycle; exactly one tlast.
- Partial last: tlast=1, keep=4'b0011, data 0x44332211 → outputs 0x11, then 0x22 with tlast=1; the next input is accepted in the same cycle as 0x22.
- Zero keep: tlast=1, keep=4'b0000, data 0x000000EE → single output 0xEE with tlast=1.
- Backpressure: random axis_o_tready with 30% low cycles over 1000 packets → output stream equals the reference-model byte stream; data, tlast and tuser stay stable while valid && !ready.
- Reset mid-packet: assert aresetn low after 2 of 4 lanes → axis_o_tvalid=0 immediately and axis_i_tready=0; after release, the first output is lane 0 of the next input beat.
